// File: rtl/siso_ctrl_pkg.sv
// Shared types and helpers for the SISO stream controller and its tag pipeline.
package siso_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Bit counter width; a one-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/siso_tag_pipe.sv
// Delay line carrying {valid,last} alongside the bits travelling through shift_siso.
module siso_tag_pipe
  import siso_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  tag_t in_tag,
  output tag_t out_tag,
  output logic any_set
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: unlike a data-only pipe, every stage is reset: a stale tag would surface as a phantom valid/last.
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign out_tag = stages[DEPTH-1];

  always_comb begin
    any_set = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_set = any_set | stages[i].valid;
  end

endmodule

// File: rtl/siso_stream_ctrl.sv
// Serialises handshaked parallel words into shift_siso and qualifies its serial output.
module siso_stream_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_din,
  input  logic             sr_dout,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int            CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    count;
  logic             last_bit;
  logic             load;
  tag_t             tag_in, tag_out;
  logic             tags_busy;

  assign last_bit = (count == LAST_COUNT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    sr_din    = 1'b0;
    load      = 1'b0;
    tag_in    = '0;
    case (state)
      IDLE: begin
        // Held low during reset so a word offered then is never mistaken for a transfer.
        in_ready = ~rst;
        if (in_valid && !rst) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sr_din       = MSB_FIRST ? word[WIDTH-1] : word[0];
        tag_in.valid = 1'b1;
        tag_in.last  = last_bit;
        if (last_bit) begin
          in_ready = ~rst;
          if (in_valid && !rst) load = 1'b1;
          else                  state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        word  <= in_data;
        count <= '0;
      end else if (state == SHIFT) begin
        word <= MSB_FIRST ? (word << 1) : (word >> 1);
        if (!last_bit) count <= count + CW'(1);
      end
    end
  end

  siso_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_tag  (tag_in),
    .out_tag (tag_out),
    .any_set (tags_busy)
  );

  assign out_valid = tag_out.valid;
  assign out_last  = tag_out.valid & tag_out.last;
  assign out_bit   = tag_out.valid & sr_dout;
  assign busy      = (state != IDLE) | tags_busy;

endmodule
